// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status enable
// bit positions and the exception FSM state encoding.
package cp0_exception_unit_pkg;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_OVF     = 5'd12;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  localparam int unsigned BIT_IE      = 0;
  localparam int unsigned BIT_SYS_EN  = 1;
  localparam int unsigned BIT_BRK_EN  = 2;
  localparam int unsigned BIT_OVF_EN  = 3;
  localparam int unsigned BIT_TEQ_EN  = 4;

  // Width of the enable field that shifts on exception entry and eret.
  localparam int unsigned EN_W = 5;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  function automatic logic [31:0] cause_word(input logic [4:0] code);
    cause_word = {25'd0, code, 2'd0};
  endfunction

endpackage

// File: rtl/cp0_exception_unit_priority_enc.sv
// Fixed-priority exception request encoder. Only the highest asserted request
// is considered; if its enable (or global IE) is clear the request is dropped.
module exc_priority_enc
  import cp0_exception_unit_pkg::*;
(
  input  logic       syscall,
  input  logic       brk,
  input  logic       ovf,
  input  logic       teq_hit,
  input  logic [4:0] en,
  output logic       req_valid,
  output logic [4:0] exc_code
);

  logic sel_en;

  always_comb begin
    sel_en   = 1'b0;
    exc_code = 5'd0;
    if (syscall) begin
      exc_code = EXC_SYSCALL;
      sel_en   = en[BIT_SYS_EN];
    end else if (brk) begin
      exc_code = EXC_BREAK;
      sel_en   = en[BIT_BRK_EN];
    end else if (ovf) begin
      exc_code = EXC_OVF;
      sel_en   = en[BIT_OVF_EN];
    end else if (teq_hit) begin
      exc_code = EXC_TEQ;
      sel_en   = en[BIT_TEQ_EN];
    end
  end

  assign req_valid = sel_en & en[BIT_IE];

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 Status/Cause/EPC register file with the RUN/HANDLER exception sequencer
// and the fetch redirect mux.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_001F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ovf,
  input  logic        syscall,
  input  logic        brk,
  input  logic        teq_hit,
  input  logic        eret,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        exc_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        in_handler
);

  state_t     state;
  logic       req_valid;
  logic [4:0] exc_code;
  logic       eret_ok;
  logic       wr_status;
  logic       wr_cause;
  logic       wr_epc;
  logic       mfc0_unused;

  assign mfc0_unused = mfc0;

  exc_priority_enc u_prio (
    .syscall   (syscall),
    .brk       (brk),
    .ovf       (ovf),
    .teq_hit   (teq_hit),
    .en        (status[EN_W-1:0]),
    .req_valid (req_valid),
    .exc_code  (exc_code)
  );

  // Reset in the same cycle overrides any request, so it is kept off the redirect too.
  assign exc_taken   = !rst && (state == ST_RUN) && req_valid;
  assign eret_ok     = !rst && (state == ST_HANDLER) && eret;
  assign redirect    = exc_taken | eret_ok;
  assign redirect_pc = exc_taken ? EXC_VECTOR : epc;

  assign wr_status = mtc0 && (addr == REG_STATUS);
  assign wr_cause  = mtc0 && (addr == REG_CAUSE);
  assign wr_epc    = mtc0 && (addr == REG_EPC);

  always_comb begin
    rdata = 32'd0;
    case (addr)
      REG_STATUS: rdata = status;
      REG_CAUSE:  rdata = cause;
      REG_EPC:    rdata = epc;
      default:    rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      in_handler <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_taken) begin
            state      <= ST_HANDLER;
            in_handler <= 1'b1;
          end
        end
        ST_HANDLER: begin
          if (eret_ok) begin
            state      <= ST_RUN;
            in_handler <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          in_handler <= 1'b0;
        end
      endcase
    end
  end

  // An accepted exception discards any mtc0 in the same cycle; eret only
  // takes priority over an mtc0 aimed at Status.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
      cause  <= 32'd0;
      epc    <= 32'd0;
    end else if (exc_taken) begin
      epc    <= pc;
      cause  <= cause_word(exc_code);
      status <= status << EN_W;
    end else begin
      if (eret_ok)
        status <= status >> EN_W;
      else if (wr_status)
        status <= wdata;
      if (wr_cause)
        cause <= wdata;
      if (wr_epc)
        epc <= wdata;
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed test of the CP0 exception unit: reset, entry/exit, masking,
// priority, same-cycle precedence and reset out of HANDLER.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ovf, syscall, brk, teq_hit, eret, mtc0, mfc0;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, redirect_pc, status, cause, epc;
  logic        exc_taken, redirect, in_handler;

  int total = 0;
  int bad   = 0;

  cp0_exception_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .ovf         (ovf),
    .syscall     (syscall),
    .brk         (brk),
    .teq_hit     (teq_hit),
    .eret        (eret),
    .mtc0        (mtc0),
    .mfc0        (mfc0),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .exc_taken   (exc_taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .status      (status),
    .cause       (cause),
    .epc         (epc),
    .in_handler  (in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ovf = 0; syscall = 0; brk = 0; teq_hit = 0; eret = 0;
    mtc0 = 0; mfc0 = 0; wdata = 32'd0;
  endtask

  initial begin
    rst = 1; pc = 32'd0; addr = 5'd0;
    idle();
    tick();
    tick();
    rst = 0;
    #1;

    // reset state
    addr = 5'd12; #1; chk("rst_rd_status", rdata, 32'h0000_001F);
    addr = 5'd13; #1; chk("rst_rd_cause", rdata, 32'h0);
    addr = 5'd14; #1; chk("rst_rd_epc", rdata, 32'h0);
    chk("rst_exc_taken", {31'd0, exc_taken}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_in_handler", {31'd0, in_handler}, 32'd0);

    // overflow exception
    pc = 32'h0040_0020; ovf = 1; #1;
    chk("ovf_taken", {31'd0, exc_taken}, 32'd1);
    chk("ovf_redirect", {31'd0, redirect}, 32'd1);
    chk("ovf_redirect_pc", redirect_pc, 32'h0040_0004);
    tick(); idle();
    chk("ovf_epc", epc, 32'h0040_0020);
    chk("ovf_cause", cause, 32'h0000_0030);
    chk("ovf_status", status, 32'h0000_03E0);
    chk("ovf_in_handler", {31'd0, in_handler}, 32'd1);

    // request ignored in HANDLER
    syscall = 1; #1;
    chk("hdl_sys_taken", {31'd0, exc_taken}, 32'd0);
    chk("hdl_sys_redirect", {31'd0, redirect}, 32'd0);
    tick(); idle();
    chk("hdl_sys_cause", cause, 32'h0000_0030);
    chk("hdl_sys_epc", epc, 32'h0040_0020);
    chk("hdl_sys_status", status, 32'h0000_03E0);

    // eret back to RUN
    eret = 1; #1;
    chk("eret_redirect", {31'd0, redirect}, 32'd1);
    chk("eret_redirect_pc", redirect_pc, 32'h0040_0020);
    tick(); idle();
    chk("eret_status", status, 32'h0000_001F);
    chk("eret_in_handler", {31'd0, in_handler}, 32'd0);

    // eret in RUN is a NOP
    eret = 1; #1;
    chk("run_eret_redirect", {31'd0, redirect}, 32'd0);
    tick(); idle();
    chk("run_eret_status", status, 32'h0000_001F);

    // mtc0 Status, no bypass on read
    mtc0 = 1; addr = 5'd12; wdata = 32'h0000_0017; #1;
    chk("mtc0_nobypass", rdata, 32'h0000_001F);
    tick(); idle();
    chk("mtc0_status", status, 32'h0000_0017);

    // overflow masked: no exception
    ovf = 1; #1;
    chk("ovf_masked_taken", {31'd0, exc_taken}, 32'd0);
    chk("ovf_masked_redirect", {31'd0, redirect}, 32'd0);
    tick(); idle();
    chk("ovf_masked_hdl", {31'd0, in_handler}, 32'd0);
    chk("ovf_masked_epc", epc, 32'h0040_0020);

    // syscall beats ovf; exception discards same-cycle mtc0 EPC
    pc = 32'h0040_0100; syscall = 1; ovf = 1;
    mtc0 = 1; addr = 5'd14; wdata = 32'hDEAD_BEEF; #1;
    chk("sys_taken", {31'd0, exc_taken}, 32'd1);
    tick(); idle();
    chk("sys_cause", cause, 32'h0000_0020);
    chk("sys_epc", epc, 32'h0040_0100);
    chk("sys_status", status, 32'h0000_02E0);

    // mtc0 EPC legal in HANDLER
    mtc0 = 1; addr = 5'd14; wdata = 32'h0040_0300;
    tick(); idle();
    chk("hdl_mtc0_epc", epc, 32'h0040_0300);

    // eret beats mtc0 Status
    eret = 1; mtc0 = 1; addr = 5'd12; wdata = 32'hFFFF_FFFF; #1;
    chk("eret2_redirect_pc", redirect_pc, 32'h0040_0300);
    tick(); idle();
    chk("eret2_status", status, 32'h0000_0017);
    chk("eret2_in_handler", {31'd0, in_handler}, 32'd0);

    // unmapped address: read 0, write ignored; Cause writable
    mtc0 = 1; addr = 5'd5; wdata = 32'h0000_1234; #1;
    chk("unmapped_rd", rdata, 32'h0);
    tick(); idle();
    chk("unmapped_status", status, 32'h0000_0017);
    mtc0 = 1; addr = 5'd13; wdata = 32'h0000_ABCD;
    tick(); idle();
    chk("mtc0_cause", cause, 32'h0000_ABCD);

    // masked highest-priority request drops lower ones
    mtc0 = 1; addr = 5'd12; wdata = 32'h0000_001D;
    tick(); idle();
    syscall = 1; ovf = 1; #1;
    chk("sys_masked_taken", {31'd0, exc_taken}, 32'd0);
    tick(); idle();

    // IE clear masks everything
    mtc0 = 1; addr = 5'd12; wdata = 32'h0000_001E;
    tick(); idle();
    teq_hit = 1; #1;
    chk("ie_off_taken", {31'd0, exc_taken}, 32'd0);
    tick(); idle();

    // teq exception
    mtc0 = 1; addr = 5'd12; wdata = 32'h0000_001F;
    tick(); idle();
    pc = 32'h0040_0400; teq_hit = 1; #1;
    chk("teq_taken", {31'd0, exc_taken}, 32'd1);
    tick(); idle();
    chk("teq_cause", cause, 32'h0000_0034);
    chk("teq_epc", epc, 32'h0040_0400);

    // reset in HANDLER with a pending request
    rst = 1; teq_hit = 1;
    tick(); idle(); rst = 0; #1;
    chk("rst2_in_handler", {31'd0, in_handler}, 32'd0);
    chk("rst2_status", status, 32'h0000_001F);
    chk("rst2_cause", cause, 32'h0);
    chk("rst2_epc", epc, 32'h0);

    // break beats ovf and teq
    pc = 32'h0040_0500; brk = 1; ovf = 1; teq_hit = 1; #1;
    chk("brk_taken", {31'd0, exc_taken}, 32'd1);
    tick(); idle();
    chk("brk_cause", cause, 32'h0000_0024);
    chk("brk_epc", epc, 32'h0040_0500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
